mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
- Upstream controller for the 13-channel, single-bit, 4-bit-select channel mux.
- Steps the mux select through every channel in order, waits a settle interval per channel, and samples the mux output bit into a channel word.
- Presents the completed NUM_CH-bit snapshot downstream with a valid/ready handshake.
- Supports one-shot and continuous scanning.

Parameters:
- NUM_CH, 13, number of mux channels scanned; legal range 2..16.
- SEL_W, 4, select width; must satisfy 2**SEL_W >= NUM_CH.
- SETTLE, 2, idle cycles after each select change before sampling; legal range 0..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle scan request; honoured only in IDLE.
- cont_mode  input  1  1 = rescan automatically after each accepted snapshot.
- mux_sel  output  SEL_W  select driven to the channel mux.
- mux_out  input  1  selected bit returned from the channel mux.
- busy  output  1  high in every state except IDLE.
- data_out  output  NUM_CH  snapshot; bit n = channel n sample.
- data_valid  output  1  snapshot available.
- data_ready  input  1  downstream accepts snapshot.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: mux_sel=0, busy=0, data_out=0, data_valid=0, state=IDLE, internal shift/capture register=0, settle counter=0.
- Reset mid-scan or mid-handshake: takes effect at the next edge; partial data is discarded.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - mux_sel=0.
  - start=1 -> SETTLE with channel index=0 and settle count=0.
  - start is ignored in all other states; there is no queuing.
- SETTLE:
  - mux_sel holds the current index.
  - Counts SETTLE cycles, then -> SAMPLE.
  - SETTLE=0 skips the state entirely (IDLE/SAMPLE go directly to SAMPLE).
- SAMPLE (1 cycle):
  - capture[index] <= mux_out.
  - index < NUM_CH-1: index+1, -> SETTLE.
  - index = NUM_CH-1: data_out <= completed capture including this bit, data_valid <= 1, -> DONE.
- DONE:
  - data_out and data_valid are held stable until data_valid & data_ready.
  - On acceptance: data_valid <= 0 in the same edge.
  - Then cont_mode=1 -> SETTLE with index=0; cont_mode=0 -> IDLE.
  - cont_mode is sampled only at the acceptance edge.
- data_ready while data_valid=0 has no effect.
- Latency:
  - Start-sampled edge to data_valid high = 1 + NUM_CH*(SETTLE+1) cycles (40 at defaults).
  - Back-to-back continuous scans: acceptance to next data_valid = NUM_CH*(SETTLE+1) cycles.
- mux_sel never takes a value >= NUM_CH, so for NUM_CH=13 select codes 13-15 are never driven.
- mux_sel changes only on the edge entering SETTLE, or SAMPLE when SETTLE=0. It is stable throughout each settle window and its sample cycle.
- Settle counter width is ceil(log2(SETTLE+1)) minimum 1; it wraps to 0 on each state exit.
- Index increments without wrap beyond NUM_CH-1.
- Simultaneous rst and start: rst wins.

Optional Feature:
- Macro: SCAN_PARITY_EN.
- When defined:
  - Adds output scan_parity (1 bit), reset 0.
  - Loaded at the same edge as data_out with the XOR of all NUM_CH snapshot bits (even-parity result; 1 when an odd number of ones).
  - Held with data_out.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle, defaults: mux_sel=0, busy=0, data_valid=0, data_out=0 for 20 cycles with start low.
- Mux model returns channel n = pattern 13'h1A5B bit n; pulse start, data_ready=1, cont_mode=0:
  - data_valid rises 40 cycles after start, data_out=13'h1A5B, 1-cycle pulse, then IDLE/busy=0.
  - mux_sel sequence 0..12, each held 3 cycles, never 13-15.
- Backpressure: data_ready=0 for 10 cycles after valid:
  - data_out and data_valid stable throughout.
  - Accepted on the first ready cycle; start pulses during DONE/SETTLE are ignored (exactly one snapshot).
- Continuous mode: cont_mode=1, pattern changes to 13'h0F0F after the first snapshot:
  - Second valid 39 cycles after the first acceptance with data_out=13'h0F0F.
- Reset mid-scan at mux_sel=6: next cycle mux_sel=0, busy=0, data_valid=0; a subsequent full scan returns a correct word with no stale bits.
- SETTLE=0 build, plus SCAN_PARITY_EN: valid 14 cycles after start; pattern 13'h0007 -> scan_parity=1, 13'h0003 -> scan_parity=0.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - sequences a channel mux select, samples each channel into a snapshot word
// Optional feature macro: SCAN_PARITY_EN adds the scan_parity output.
module mux_scan_sequencer #(
    parameter int NUM_CH = 13,
    parameter int SEL_W  = 4,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont_mode,
    output logic [SEL_W-1:0]  mux_sel,
    input  logic              mux_out,
    output logic              busy,
    output logic [NUM_CH-1:0] data_out,
    output logic              data_valid,
`ifdef SCAN_PARITY_EN
    output logic              scan_parity,
`endif
    input  logic              data_ready
);

    localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam int CNT_LAST_I = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);
    localparam bit SKIP_SETTLE = (SETTLE == 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [SEL_W-1:0]    r_sel;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_CH-1:0]   r_cap;
    logic [NUM_CH-1:0]   r_data;
    logic                r_valid;
    logic                r_busy;
    logic [NUM_CH-1:0]   w_cap_next;
`ifdef SCAN_PARITY_EN
    logic                r_parity;
`endif

    // Capture word with the bit currently being sampled merged in, so the last
    // channel lands in the snapshot on the same edge it is sampled.
    always_comb begin
        w_cap_next        = r_cap;
        w_cap_next[r_sel] = mux_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sel    <= '0;
            r_cnt    <= '0;
            r_cap    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
`ifdef SCAN_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_sel <= '0;
                    if (start) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SKIP_SETTLE ? S_SAMPLE : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    r_cap <= w_cap_next;
                    if (r_sel == SEL_LAST) begin
                        r_data   <= w_cap_next;
                        r_valid  <= 1'b1;
`ifdef SCAN_PARITY_EN
                        r_parity <= ^w_cap_next;
`endif
                        r_state  <= S_DONE;
                    end else begin
                        r_sel   <= r_sel + SEL_W'(1);
                        r_state <= SKIP_SETTLE ? S_SAMPLE : S_SETTLE;
                    end
                end
                S_DONE: begin
                    // Select stays on the last channel until the snapshot is taken.
                    if (data_ready) begin
                        r_valid <= 1'b0;
                        r_sel   <= '0;
                        r_cnt   <= '0;
                        if (cont_mode) begin
                            r_state <= SKIP_SETTLE ? S_SAMPLE : S_SETTLE;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_sel   <= '0;
                end
            endcase
        end
    end

    assign mux_sel    = r_sel;
    assign busy       = r_busy;
    assign data_out   = r_data;
    assign data_valid = r_valid;
`ifdef SCAN_PARITY_EN
    assign scan_parity = r_parity;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - directed bench for mux_scan_sequencer, SETTLE=2 and SETTLE=0 instances
module tb_mux_scan_sequencer;

    localparam int NUM = 13;

    logic clk = 1'b0;
    logic rst, start, cont, ready;
    logic [NUM-1:0] pat;

    logic [3:0]     sel  [2];
    logic           busy_a [2];
    logic [NUM-1:0] dout [2];
    logic           dval [2];
    logic           mo   [2];
`ifdef SCAN_PARITY_EN
    logic           par  [2];
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    assign mo[0] = pat[sel[0]];
    assign mo[1] = pat[sel[1]];

    mux_scan_sequencer #(.NUM_CH(NUM), .SEL_W(4), .SETTLE(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .cont_mode(cont),
        .mux_sel(sel[0]), .mux_out(mo[0]), .busy(busy_a[0]),
        .data_out(dout[0]), .data_valid(dval[0]),
`ifdef SCAN_PARITY_EN
        .scan_parity(par[0]),
`endif
        .data_ready(ready)
    );

    mux_scan_sequencer #(.NUM_CH(NUM), .SEL_W(4), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .cont_mode(cont),
        .mux_sel(sel[1]), .mux_out(mo[1]), .busy(busy_a[1]),
        .data_out(dout[1]), .data_valid(dval[1]),
`ifdef SCAN_PARITY_EN
        .scan_parity(par[1]),
`endif
        .data_ready(ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Model: a scan is a timeline of NUM*(S+1) cycles; channel k occupies
    // cycles k*(S+1)..k*(S+1)+S and is sampled on its last cycle.
    bit             m_act [2];
    bit             m_val [2];
    int             m_t   [2];
    logic [NUM-1:0] m_cap [2];
    logic [NUM-1:0] m_data [2];
    int             ms, mp;

    function automatic int settle_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ms = settle_of(i);
            mp = ms + 1;
            if (rst) begin
                m_act[i] = 1'b0; m_val[i] = 1'b0; m_t[i] = 0;
                m_cap[i] = '0;   m_data[i] = '0;
            end else if (m_val[i]) begin
                if (ready) begin
                    m_val[i] = 1'b0;
                    m_act[i] = cont;
                    m_t[i]   = 0;
                end
            end else if (m_act[i]) begin
                if (m_t[i] % mp == ms) m_cap[i][m_t[i] / mp] = pat[m_t[i] / mp];
                if (m_t[i] == NUM * mp - 1) begin
                    m_act[i]  = 1'b0;
                    m_val[i]  = 1'b1;
                    m_data[i] = m_cap[i];
                end else begin
                    m_t[i] = m_t[i] + 1;
                end
            end else if (start) begin
                m_act[i] = 1'b1;
                m_t[i]   = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("cmp%0d_busy", i), 32'(busy_a[i]), 32'(m_act[i] | m_val[i]));
                chk($sformatf("cmp%0d_valid", i), 32'(dval[i]), 32'(m_val[i]));
                chk($sformatf("cmp%0d_data", i), 32'(dout[i]), 32'(m_data[i]));
                chk($sformatf("cmp%0d_sel", i), 32'(sel[i]),
                    m_act[i] ? 32'(m_t[i] / (settle_of(i) + 1)) : (m_val[i] ? 32'(NUM - 1) : 32'd0));
                chk($sformatf("cmp%0d_sel_range", i), 32'(sel[i] < 4'(NUM)), 32'd1);
`ifdef SCAN_PARITY_EN
                chk($sformatf("cmp%0d_parity", i), 32'(par[i]), 32'(^m_data[i]));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advances until instance inst shows data_valid; drops start after the first edge.
    task automatic wait_valid(input int inst, input int max, input string nm, output int lat);
        lat = 0;
        for (int n = 1; n <= max && lat == 0; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (dval[inst]) lat = n;
        end
        if (lat == 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s timeout actual=none expected=valid", nm);
        end
    endtask

    task automatic wait_idle(input int max, input string nm);
        int n;
        n = 0;
        while ((busy_a[0] || busy_a[1]) && n < max) begin
            tick();
            n++;
        end
        chk(nm, 32'(busy_a[0] | busy_a[1]), 32'd0);
    endtask

    int lat0, lat1, nv0, lat;
    logic [NUM-1:0] d0, d1;

    initial begin
        rst = 1'b1; start = 1'b0; cont = 1'b0; ready = 1'b1; pat = '0;
        tick(); tick();
        chk_en = 1'b1;
        rst = 1'b0;

        // Idle after reset
        repeat (20) tick();
        chk("idle_sel", 32'(sel[0]), 32'd0);
        chk("idle_busy", 32'(busy_a[0]), 32'd0);
        chk("idle_valid", 32'(dval[0]), 32'd0);
        chk("idle_data", 32'(dout[0]), 32'd0);

        // One-shot scan, ready always high
        pat = 13'h1A5B; start = 1'b1; lat0 = 0; lat1 = 0; nv0 = 0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (n <= 39) chk("t2_sel_seq", 32'(sel[0]), 32'((n - 1) / 3));
            if (dval[0]) nv0++;
            if (dval[0] && lat0 == 0) begin lat0 = n; d0 = dout[0]; end
            if (dval[1] && lat1 == 0) begin lat1 = n; d1 = dout[1]; end
        end
        chk("t2_latency", 32'(lat0), 32'd40);
        chk("t2_data", 32'(d0), 32'h1A5B);
        chk("t2_pulse_len", 32'(nv0), 32'd1);
        chk("t2_busy_after", 32'(busy_a[0]), 32'd0);
        chk("t2_s0_latency", 32'(lat1), 32'd14);
        chk("t2_s0_data", 32'(d1), 32'h1A5B);

        // Backpressure with ignored start pulses
        ready = 1'b0; start = 1'b1; lat = 0;
        for (int n = 1; n <= 60 && lat == 0; n++) begin
            tick();
            start = (n == 5);
            if (dval[0]) lat = n;
        end
        start = 1'b0;
        chk("t3_latency", 32'(lat), 32'd40);
        for (int k = 1; k <= 10; k++) begin
            chk("t3_hold_valid", 32'(dval[0]), 32'd1);
            chk("t3_hold_data", 32'(dout[0]), 32'h1A5B);
            start = (k == 3);
            tick();
        end
        start = 1'b0; ready = 1'b1;
        tick();
        chk("t3_accept_valid", 32'(dval[0]), 32'd0);
        chk("t3_accept_s0", 32'(dval[1]), 32'd0);
        nv0 = 0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (dval[0]) nv0++;
        end
        chk("t3_no_extra_scan", 32'(nv0), 32'd0);
        chk("t3_busy", 32'(busy_a[0]), 32'd0);

        // Continuous mode, pattern switch after the first snapshot
        cont = 1'b1; start = 1'b1;
        wait_valid(0, 60, "t4_first", lat);
        chk("t4_first_data", 32'(dout[0]), 32'h1A5B);
        pat = 13'h0F0F;
        lat = 0;
        for (int n = 1; n <= 60 && lat == 0; n++) begin
            tick();
            if (dval[0]) lat = n;
        end
        chk("t4_acc_to_valid", 32'(lat - 1), 32'd39);
        chk("t4_second_data", 32'(dout[0]), 32'h0F0F);
        cont = 1'b0;
        wait_idle(100, "t4_stop");

        // Reset mid-scan
        pat = 13'h1FFF; start = 1'b1; lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (sel[0] == 4'd6) lat = n;
        end
        chk("t5_reached_sel6", 32'(lat), 32'd19);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_sel", 32'(sel[0]), 32'd0);
        chk("t5_rst_busy", 32'(busy_a[0]), 32'd0);
        chk("t5_rst_valid", 32'(dval[0]), 32'd0);
        chk("t5_rst_data", 32'(dout[0]), 32'd0);
        pat = 13'h0555; start = 1'b1;
        wait_valid(0, 60, "t5_rescan", lat);
        chk("t5_rescan_data", 32'(dout[0]), 32'h0555);
        wait_idle(10, "t5_idle");

        // SETTLE=0 instance with parity patterns
        pat = 13'h0007; start = 1'b1;
        wait_valid(1, 30, "t6_a", lat);
        chk("t6_a_latency", 32'(lat), 32'd14);
        chk("t6_a_data", 32'(dout[1]), 32'h0007);
`ifdef SCAN_PARITY_EN
        chk("t6_a_parity", 32'(par[1]), 32'd1);
`endif
        wait_idle(60, "t6_a_idle");
        pat = 13'h0003; start = 1'b1;
        wait_valid(1, 30, "t6_b", lat);
        chk("t6_b_latency", 32'(lat), 32'd14);
        chk("t6_b_data", 32'(dout[1]), 32'h0003);
`ifdef SCAN_PARITY_EN
        chk("t6_b_parity", 32'(par[1]), 32'd0);
`endif
        wait_idle(60, "t6_b_idle");

        tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
